// File: rtl/multiplier_4bit_seq.sv
// Sequential shift-and-add multiply-accumulate: a = q*b + r over W cycles.
// Inverse/checker path for the combinational divider (start/busy/done handshake).
module multiplier_4bit_seq #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   q,
  input  logic [W-1:0]   b,
  input  logic [W-1:0]   r,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] a
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [W-1:0]     mq_r;
  logic [2*W-1:0]   mb_r;
  logic [2*W-1:0]   acc_r;
  logic [CW-1:0]    cnt_r;
  logic [2*W-1:0]   sum_s;

  // Conditional partial-product add for the current multiplier bit
  always_comb begin
    sum_s = acc_r;
    if (mq_r[0]) begin
      sum_s = acc_r + mb_r;
    end else begin
      sum_s = acc_r;
    end
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      mq_r    <= {W{1'b0}};
      mb_r    <= {(2*W){1'b0}};
      acc_r   <= {(2*W){1'b0}};
      cnt_r   <= {CW{1'b0}};
      a       <= {(2*W){1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state_r <= CALC;
            mq_r    <= q;
            mb_r    <= {{W{1'b0}}, b};
            acc_r   <= {{W{1'b0}}, r};
            cnt_r   <= {CW{1'b0}};
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        CALC: begin
          // start is deliberately ignored here; no queueing
          acc_r <= sum_s;
          mq_r  <= {1'b0, mq_r[W-1:1]};
          mb_r  <= {mb_r[2*W-2:0], 1'b0};
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == CW'(W - 1)) begin
            state_r <= DONE;
            a       <= sum_s;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state_r <= CALC;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/multiplier_4bit_seq.md
# multiplier_4bit_seq

Sequential shift-and-add multiply-accumulate unit that reconstructs a dividend from a divider result: it computes `a = q*b + r` over W clock cycles. It sits alongside the combinational 4-bit divider as its inverse/checker path. Feeding it the divider's `q`, `r` and the original `b` must return the original `a`. Start/busy/done handshake; result held until the next operation.

## Interface
- `W`, 4, operand width; result width is 2W
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE or DONE
- `q`  in  W  multiplier (quotient)
- `b`  in  W  multiplicand (divisor)
- `r`  in  W  addend (remainder)
- `busy`  out  1  high while in CALC
- `done`  out  1  one-cycle pulse, high in DONE state
- `a`  out  2W  result `q*b + r`; registered, held between operations

## Operation
- States:
  - IDLE: waiting; `busy=0`, `done=0`.
  - CALC: iterating; `busy=1`, `done=0`.
  - DONE: result presented; `busy=0`, `done=1`.
- Accept (IDLE or DONE, `start=1` at edge):
  - Latch `q` into shift register `mq`.
  - Latch `b` zero-extended to 2W into `mb`.
  - Load accumulator `acc <= {W'b0, r}`, counter `cnt <= 0`.
  - Go to CALC.
- CALC, each edge:
  - If `mq[0]`, then `acc <= acc + mb`.
  - Then `mq <= mq >> 1`, `mb <= mb << 1`, `cnt <= cnt + 1`.
  - On the edge where `cnt == W-1`: write the final sum into `a` and go to DONE.
- DONE, next edge: go to CALC if `start=1` (back-to-back accept), else to IDLE.
- Width rule: max result is `(2^W-1)^2 + (2^W-1) = 2^2W - 2^W`, so 2W bits never overflow. No overflow flag.
- Output `a` changes only at CALC completion. It never shows partial sums and holds through IDLE and subsequent CALC.
- Inputs `q/b/r` are don't-care except at the accept edge; changes during CALC have no effect.
- `start` during CALC is ignored; there is no queueing.
- Edge cases:
  - `q=0` or `b=0`: result is `r` after the full W cycles; no early exit.
- Reset (any state, including mid-CALC): state to IDLE; `a=0`, `busy=0`, `done=0`, `acc/mq/mb/cnt=0`. The in-flight operation is discarded with no `done` pulse.

## Timing
- Reset values: `a=0`, `busy=0`, `done=0`.
- Latency: `start` sampled at edge 0 gives CALC for edges 1..W, and the result is written at edge W.
  - `busy` is high after edge 0 through edge W.
  - `done` and the valid `a` appear after edge W.
  - `done` deasserts after edge W+1 unless restarted.
  - W=4: 4 cycles from accept to result.
- Throughput: one operation per W+1 cycles with `start` held high continuously.
- `busy` and `done` are never simultaneously high.
- Exactly one `done` pulse per accepted `start`, except when `rst` intervenes.

## Test plan
- `q=13, b=11, r=7`, pulse `start` → `busy` high for 4 cycles, then `done` for 1 cycle with `a=150 (0x96)`; `a` held after.
- `q=15, b=15, r=15` → `a=240 (0xF0)`, no overflow. Also run `q=0, b=9, r=5` → `a=5` and `q=6, b=0, r=3` → `a=3`, each after a full 4-cycle latency.
- Pulse `start` with `q=3, b=4, r=1`. During CALC, change inputs to `q=15, b=15, r=0` and pulse `start` again → `a=13`, single `done`, and the second `start` is ignored.
- Hold `start=1` for 3 operations (`2*3+1`, `5*5+0`, `9*7+6`) → `done` every 5 cycles with `a=7`, then `25`, then `69`; `busy` returns high the cycle after each `done`.
- Assert `rst` for 1 cycle two edges into CALC → next cycle `busy=0`, `done=0`, `a=0`, no `done` pulse. A following `start` with `q=2, b=2, r=2` → `a=6`.
- Exhaustive W=4 sweep of all `a` (0..15) and `b` (1..15): compute `q, r` by repeated subtraction and run the block → `a_out == a` in every case.
